// File: rtl/fpu_req_driver.sv
// fpu_req_driver: valid/ready front end for the fpu datapath, returning tagged results in request order.
// Optional feature macro FPU_DRV_FLAGS_EN adds rsp_flags = {nan, inf, zero, neg} per response.
module fpu_req_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned FPU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_DRV_FLAGS_EN
  output logic [3:0]       rsp_flags,
`endif
  output logic [1:0]       rsp_op
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STG   = FPU_LAT + 1;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
`ifdef FPU_DRV_FLAGS_EN
    logic [3:0]       flags;
`endif
  } entry_t;

`ifdef FPU_DRV_FLAGS_EN
  // {nan, inf, zero, neg} classification of an IEEE-754 single
  function automatic logic [3:0] fp_flags(input logic [31:0] v);
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = &v[30:23];
    exp_zero = ~|v[30:23];
    man_zero = ~|v[22:0];
    return {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero, v[31]};
  endfunction
`endif

  logic                      accept;
  logic                      pop;
  logic                      wr;
  logic [STG-1:0]            pipe_vld;
  logic [STG-1:0][TAG_W-1:0] pipe_tag;
  logic [STG-1:0][1:0]       pipe_op;
  entry_t                    mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          rd_ptr_nxt;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [CNT_W-1:0]          fifo_cnt_nxt;
  logic [CNT_W-1:0]          remain;
  logic [CNT_W-1:0]          out_cnt;
  logic [CNT_W-1:0]          out_cnt_nxt;
  entry_t                    wdata;
  entry_t                    head_nxt;

  assign accept = req_valid & req_ready;
  assign pop    = rsp_valid & rsp_ready;
  assign wr     = pipe_vld[STG-1];

  // Entry captured from the fpu when the matching pipeline slot reaches the end
  always_comb begin
    wdata      = '0;
    wdata.data = fpu_out;
    wdata.tag  = pipe_tag[STG-1];
    wdata.op   = pipe_op[STG-1];
`ifdef FPU_DRV_FLAGS_EN
    wdata.flags = fp_flags(fpu_out);
`endif
  end

  // Next counts/pointers and the entry that will sit at the head after this edge
  always_comb begin
    fifo_cnt_nxt = fifo_cnt + CNT_W'(wr) - CNT_W'(pop);
    out_cnt_nxt  = out_cnt + CNT_W'(accept) - CNT_W'(pop);
    rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
    remain       = fifo_cnt - CNT_W'(pop);
    head_nxt     = (remain == '0) ? wdata : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= '0;
      pipe_vld   <= '0;
      pipe_tag   <= '0;
      pipe_op    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      out_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_op     <= '0;
`ifdef FPU_DRV_FLAGS_EN
      rsp_flags  <= '0;
`endif
    end else begin
      // Credit: everything issued and not yet popped must fit in the FIFO
      req_ready <= (out_cnt_nxt < CNT_W'(DEPTH));
      out_cnt   <= out_cnt_nxt;

      if (accept) begin
        fpu_a       <= req_a;
        fpu_b       <= req_b;
        fpu_opcode  <= req_op;
        pipe_tag[0] <= req_tag;
        pipe_op[0]  <= req_op;
      end
      pipe_vld[0] <= accept;
      for (int i = 1; i < STG; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
        pipe_op[i]  <= pipe_op[i-1];
      end

      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      rsp_valid <= (fifo_cnt_nxt != '0);

      // Head registers only move when a new entry becomes the head
      if (fifo_cnt_nxt != '0) begin
        rsp_data  <= head_nxt.data;
        rsp_tag   <= head_nxt.tag;
        rsp_op    <= head_nxt.op;
`ifdef FPU_DRV_FLAGS_EN
        rsp_flags <= head_nxt.flags;
`endif
      end
    end
  end

  // Response storage; contents are only meaningful under the pointers
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr] <= wdata;
  end

endmodule
